// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Multi-cycle sequencer for the harvard MIPS control path. It produces the
// fetch/execute `state` bit used by the combinational `control` decoder and
// adds the following on top of it:
//   - variable-latency stalls for MULT/MULTU/DIV/DIVU and for memory wait;
//   - a terminal halt state;
//   - a retired-instruction counter.
//
// Ports:
//   clk                 system clock, rising edge
//   reset_n             asynchronous active-low reset
//   instruction_opcode  opcode of the instruction held in the IR
//   func_code           func field of the instruction held in the IR
//   mem_waitrequest     instruction/data memory not ready this cycle
//   halt_req            halt condition, honoured only in a retire cycle
//   state               0 = fetch, 1 = execute
//   state_code          IDLE=0 FETCH=1 EXEC=2 MD_WAIT=3 MEM_WAIT=4 HALT=5
//   ir_write            latch fetched instruction into IR
//   pc_write            update PC; marks instruction retire
//   muldiv_start        one-cycle start pulse to the mul/div unit
//   hilo_write          commit mul/div result to HI/LO
//   stall               high in MD_WAIT or MEM_WAIT
//   active              CPU running (low in IDLE and HALT)
//   retired             count of pc_write pulses, wraps silently
//
// Outputs are decoded from the registered state and counter, qualified by
// mem_waitrequest where the memory handshake requires it, so ir_write and
// pc_write can react in the same cycle the memory becomes ready.
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6,
    parameter int RETIRE_W   = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [5:0]          instruction_opcode,
    input  logic [5:0]          func_code,
    input  logic                mem_waitrequest,
    input  logic                halt_req,
    output logic                state,
    output logic [2:0]          state_code,
    output logic                ir_write,
    output logic                pc_write,
    output logic                muldiv_start,
    output logic                hilo_write,
    output logic                stall,
    output logic                active,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MD_WAIT  = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;

    // Counter reload values: MD_WAIT lasts reload+1 cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [RETIRE_W-1:0]   retired_r;

    logic                  is_mul_s;
    logic                  is_div_s;
    logic                  is_mem_s;
    logic                  cnt_zero_s;
    state_t                retire_dest_s;

    // Instruction class decode of the IR contents.
    always_comb begin
        is_mul_s      = (instruction_opcode == OP_SPECIAL) &&
                        ((func_code == FN_MULT) || (func_code == FN_MULTU));
        is_div_s      = (instruction_opcode == OP_SPECIAL) &&
                        ((func_code == FN_DIV) || (func_code == FN_DIVU));
        is_mem_s      = (instruction_opcode == OP_LW) || (instruction_opcode == OP_SW);
        cnt_zero_s    = (cnt_r == {CNT_W{1'b0}});
        // halt_req only matters in a retire cycle, which is where this is used.
        if (halt_req) begin
            retire_dest_s = ST_HALT;
        end else begin
            retire_dest_s = ST_FETCH;
        end
    end

    // Output decode from registered state/counter plus memory handshake.
    always_comb begin
        state        = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        muldiv_start = 1'b0;
        hilo_write   = 1'b0;
        stall        = 1'b0;
        active       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                active = 1'b0;
            end
            ST_FETCH: begin
                active   = 1'b1;
                ir_write = ~mem_waitrequest;
            end
            ST_EXEC: begin
                state  = 1'b1;
                active = 1'b1;
                if (is_mul_s || is_div_s) begin
                    muldiv_start = 1'b1;
                end else if (is_mem_s && mem_waitrequest) begin
                    pc_write = 1'b0;
                end else begin
                    pc_write = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                state      = 1'b1;
                active     = 1'b1;
                stall      = 1'b1;
                hilo_write = cnt_zero_s;
                pc_write   = cnt_zero_s;
            end
            ST_MEM_WAIT: begin
                state    = 1'b1;
                active   = 1'b1;
                stall    = 1'b1;
                pc_write = ~mem_waitrequest;
            end
            ST_HALT: begin
                active = 1'b0;
            end
            default: begin
                active = 1'b0;
            end
        endcase
    end

    // Sequencer state, latency counter and retire counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            retired_r <= {RETIRE_W{1'b0}};
        end else begin
            if (pc_write) begin
                retired_r <= retired_r + RETIRE_W'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (!mem_waitrequest) begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_mul_s) begin
                        cnt_r   <= MUL_LOAD;
                        state_r <= ST_MD_WAIT;
                    end else if (is_div_s) begin
                        cnt_r   <= DIV_LOAD;
                        state_r <= ST_MD_WAIT;
                    end else if (is_mem_s && mem_waitrequest) begin
                        state_r <= ST_MEM_WAIT;
                    end else begin
                        state_r <= retire_dest_s;
                    end
                end
                ST_MD_WAIT: begin
                    if (!cnt_zero_s) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        state_r <= retire_dest_s;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_waitrequest) begin
                        state_r <= retire_dest_s;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    // Unreachable encodings fall back to a clean restart.
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign state_code = state_r;
    assign retired    = retired_r;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  instruction_opcode;
    logic [5:0]  func_code;
    logic        mem_waitrequest;
    logic        halt_req;

    logic        state, ir_write, pc_write, muldiv_start, hilo_write, stall, active;
    logic [2:0]  state_code;
    logic [31:0] retired;

    logic        state4, ir_write4, pc_write4, muldiv_start4, hilo_write4, stall4, active4;
    logic [2:0]  state_code4;
    logic [3:0]  retired4;

    // Expected per-cycle output picture.
    typedef struct packed {
        logic [2:0] code;
        logic       st;
        logic       irw;
        logic       pcw;
        logic       mds;
        logic       hlw;
        logic       stl;
        logic       act;
    } exp_t;

    int          checks  = 0;
    int          errors  = 0;
    int unsigned ret_cnt = 0;

    always #5 clk = ~clk;

    control_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6), .RETIRE_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .instruction_opcode(instruction_opcode), .func_code(func_code),
        .mem_waitrequest(mem_waitrequest), .halt_req(halt_req),
        .state(state), .state_code(state_code), .ir_write(ir_write),
        .pc_write(pc_write), .muldiv_start(muldiv_start), .hilo_write(hilo_write),
        .stall(stall), .active(active), .retired(retired)
    );

    control_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6), .RETIRE_W(4)) dut_w4 (
        .clk(clk), .reset_n(reset_n),
        .instruction_opcode(instruction_opcode), .func_code(func_code),
        .mem_waitrequest(mem_waitrequest), .halt_req(halt_req),
        .state(state4), .state_code(state_code4), .ir_write(ir_write4),
        .pc_write(pc_write4), .muldiv_start(muldiv_start4), .hilo_write(hilo_write4),
        .stall(stall4), .active(active4), .retired(retired4)
    );

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected outputs for a state: state/stall/active follow from the state alone.
    function automatic exp_t E(input logic [2:0] c, input logic irw, input logic pcw,
                               input logic mds, input logic hlw);
        exp_t e;
        e.code = c;
        e.st   = (c == 3'd2) || (c == 3'd3) || (c == 3'd4);
        e.stl  = (c == 3'd3) || (c == 3'd4);
        e.act  = (c >= 3'd1) && (c <= 3'd4);
        e.irw  = irw;
        e.pcw  = pcw;
        e.mds  = mds;
        e.hlw  = hlw;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        exp_t o;
        exp_t o4;
        o  = {state_code, state, ir_write, pc_write, muldiv_start, hilo_write, stall, active};
        o4 = {state_code4, state4, ir_write4, pc_write4, muldiv_start4, hilo_write4, stall4, active4};
        chk({tag, "/outs"},   {22'd0, o},  {22'd0, e});
        chk({tag, "/outs4"},  {22'd0, o4}, {22'd0, e});
        chk({tag, "/ret32"},  retired,          ret_cnt);
        chk({tag, "/ret4"},   {28'd0, retired4}, ret_cnt % 32'd16);
    endtask

    // One clock cycle: drive inputs, check mid-cycle, account for retire.
    task automatic cyc(input logic wr, input logic hr, input exp_t e, input string tag);
        mem_waitrequest = wr;
        halt_req        = hr;
        @(negedge clk);
        chk_all(tag, e);
        if (e.pcw) ret_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset check, then release and check the single IDLE cycle.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        ret_cnt = 0;
        chk_all({tag, "/in_reset"}, E(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(rb(), rb(), E(3'd0, 1'b0, 1'b0, 1'b0, 1'b0), {tag, "/idle"});
    endtask

    // One instruction from FETCH through retire, as a timed transaction.
    //   fw: fetch wait cycles; mw: cycles waitrequest is high starting in EXEC.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int fw, input int mw, input logic hlt);
        logic is_mul, is_md, is_mem;
        int   lat;
        instruction_opcode = o;
        func_code          = f;
        for (int i = 0; i < fw; i++)
            cyc(1'b1, rb(), E(3'd1, 1'b0, 1'b0, 1'b0, 1'b0), "fetch_wait");
        cyc(1'b0, rb(), E(3'd1, 1'b1, 1'b0, 1'b0, 1'b0), "fetch");
        is_mul = (o == 6'd0) && ((f == 6'd24) || (f == 6'd25));
        is_md  = (o == 6'd0) && (f >= 6'd24) && (f <= 6'd27);
        is_mem = (o == 6'd35) || (o == 6'd43);
        lat    = is_mul ? 4 : 32;
        if (is_md) begin
            cyc(rb(), rb(), E(3'd2, 1'b0, 1'b0, 1'b1, 1'b0), "exec_md");
            for (int k = 1; k <= lat; k++) begin
                if (k == lat)
                    cyc(rb(), hlt, E(3'd3, 1'b0, 1'b1, 1'b0, 1'b1), "md_last");
                else
                    cyc(rb(), rb(), E(3'd3, 1'b0, 1'b0, 1'b0, 1'b0), "md_wait");
            end
        end else if (is_mem && (mw > 0)) begin
            cyc(1'b1, rb(), E(3'd2, 1'b0, 1'b0, 1'b0, 1'b0), "exec_mem");
            for (int k = 1; k <= mw; k++) begin
                if (k == mw)
                    cyc(1'b0, hlt, E(3'd4, 1'b0, 1'b1, 1'b0, 1'b0), "mem_last");
                else
                    cyc(1'b1, rb(), E(3'd4, 1'b0, 1'b0, 1'b0, 1'b0), "mem_wait");
            end
        end else begin
            cyc(is_mem ? 1'b0 : rb(), hlt, E(3'd2, 1'b0, 1'b1, 1'b0, 1'b0), "exec");
        end
    endtask

    logic [5:0] ops [0:10];
    logic [5:0] fns [0:10];

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ADDU MULT MULTU DIV DIVU LW SW ORI BEQ SLL JR
        ops = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd35, 6'd43, 6'd13, 6'd4, 6'd0, 6'd0};
        fns = '{6'd33, 6'd24, 6'd25, 6'd26, 6'd27, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd8};
        reset_n            = 1'b0;
        instruction_opcode = 6'd0;
        func_code          = 6'd33;
        mem_waitrequest    = 1'b0;
        halt_req           = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then ADDU with no waits.
        do_reset("rst0");
        run_instr(6'd0, 6'd33, 0, 0, 1'b0);
        chk("addu_ret", retired, 32'd1);

        // MULT: 4 MD_WAIT cycles.
        run_instr(6'd0, 6'd24, 0, 0, 1'b0);
        // LW with waitrequest high 3 cycles from EXEC.
        run_instr(6'd35, 6'd0, 0, 3, 1'b0);
        // Fetch held by 2 wait cycles.
        run_instr(6'd0, 6'd33, 2, 0, 1'b0);

        // Randomised instruction stream.
        for (int n = 0; n < 60; n++) begin
            int idx;
            logic [5:0] f;
            idx = $urandom_range(0, 9);
            f   = (ops[idx] == 6'd0) ? fns[idx] : 6'($urandom_range(0, 63));
            run_instr(ops[idx], f, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        end

        // DIVU interrupted by reset in the 10th MD_WAIT cycle.
        instruction_opcode = 6'd0;
        func_code          = 6'd27;
        cyc(1'b0, rb(), E(3'd1, 1'b1, 1'b0, 1'b0, 1'b0), "divu_fetch");
        cyc(rb(), rb(), E(3'd2, 1'b0, 1'b0, 1'b1, 1'b0), "divu_exec");
        for (int k = 1; k <= 9; k++)
            cyc(rb(), rb(), E(3'd3, 1'b0, 1'b0, 1'b0, 1'b0), "divu_md");
        do_reset("rst_divu");

        // JR with halt_req: retire then HALT, inputs ignored afterwards.
        run_instr(6'd0, 6'd33, 0, 0, 1'b0);
        run_instr(6'd0, 6'd8, 0, 0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            instruction_opcode = 6'($urandom_range(0, 63));
            func_code          = 6'($urandom_range(0, 63));
            cyc(rb(), rb(), E(3'd5, 1'b0, 1'b0, 1'b0, 1'b0), "halt");
        end
        chk("halt_ret", retired, 32'd2);

        // Retire counter wrap on the 4-bit instance.
        do_reset("rst_wrap");
        for (int k = 0; k < 16; k++)
            run_instr(6'd0, 6'd33, 0, 0, 1'b0);
        chk("wrap_ret32", retired, 32'd16);
        chk("wrap_ret4", {28'd0, retired4}, 32'd0);
        run_instr(6'd0, 6'd33, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle sequencer for the harvard MIPS control path.
- Drives the fetch/execute `state` bit consumed by the combinational `control` decoder.
- Adds the behaviour the single-bit state lacks:
  - variable-latency stalls for MULT/MULTU/DIV/DIVU and for data-memory wait;
  - a halt state;
  - a retired-instruction counter.
- Sits between the instruction register/PC logic and the datapath write enables.

Parameters:
- MUL_CYCLES, 4: cycles spent in MD_WAIT for MULT/MULTU; legal range 1..2^CNT_W-1.
- DIV_CYCLES, 32: cycles spent in MD_WAIT for DIV/DIVU; legal range 1..2^CNT_W-1.
- CNT_W, 6: width of the internal latency counter.
- RETIRE_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- instruction_opcode  in  6  opcode of the instruction held in the IR
- func_code  in  6  func field of the instruction held in the IR
- mem_waitrequest  in  1  instruction/data memory not ready this cycle
- halt_req  in  1  halt condition (jump target 0), sampled on retire
- state  out  1  0 = fetch, 1 = execute; feeds `control`
- state_code  out  3  IDLE=0, FETCH=1, EXEC=2, MD_WAIT=3, MEM_WAIT=4, HALT=5
- ir_write  out  1  latch fetched instruction into IR
- pc_write  out  1  update PC; marks instruction retire
- muldiv_start  out  1  one-cycle start pulse to the mul/div unit
- hilo_write  out  1  commit mul/div result to HI/LO
- stall  out  1  high in MD_WAIT or MEM_WAIT
- active  out  1  CPU running (low in IDLE and HALT)
- retired  out  RETIRE_W  count of pc_write pulses

Behaviour:
- Reset: reset_n low forces, asynchronously:
  - state_code=IDLE, counter=0, retired=0;
  - all 1-bit outputs 0.
- Reset mid-operation (including MD_WAIT with counter non-zero) returns to IDLE with no hilo_write and no pc_write.
- All other transitions are on the rising edge of clk. All outputs are decoded from registered state, counter and inputs (Moore, plus the listed input qualifiers).
- IDLE: active=0. Goes to FETCH on the first edge after reset_n rises.
- FETCH: state=0, active=1.
  - mem_waitrequest=1: hold FETCH, ir_write=0.
  - Otherwise: ir_write=1, go to EXEC.
- EXEC: state=1. Decode priority:
  1. opcode 000000 with func 011000/011001 (MULT/MULTU): muldiv_start=1, counter<=MUL_CYCLES-1, go to MD_WAIT.
  2. opcode 000000 with func 011010/011011 (DIV/DIVU): muldiv_start=1, counter<=DIV_CYCLES-1, go to MD_WAIT.
  3. opcode 100011 (LW) or 101011 (SW) with mem_waitrequest=1: go to MEM_WAIT, pc_write=0.
  4. Otherwise: pc_write=1, retire, go to FETCH (or HALT if halt_req=1).
- MD_WAIT: state=1, stall=1.
  - counter!=0: decrement the counter.
  - counter==0: hilo_write=1, pc_write=1, retire, go to FETCH/HALT.
  - Latency: EXEC→next FETCH is exactly 1+MUL_CYCLES (or 1+DIV_CYCLES) cycles. hilo_write occurs in the last MD_WAIT cycle only.
- MEM_WAIT: state=1, stall=1.
  - Hold while mem_waitrequest=1.
  - First cycle with mem_waitrequest=0: pc_write=1, retire, go to FETCH/HALT.
- HALT: active=0, state=0, all enables 0. Stays until reset; inputs ignored.
- Retire: every cycle with pc_write=1 does retired<=retired+1, mod 2^RETIRE_W. Wraps from all-ones to 0 with no flag.
- halt_req is sampled only in a retire cycle. halt_req asserted in any other cycle has no effect.
- Simultaneous events:
  - muldiv_start and pc_write are never high in the same cycle.
  - hilo_write is only ever high together with pc_write.
  - mem_waitrequest is ignored in EXEC for non-LW/SW instructions.
- Illegal state_code (6,7) recovers to IDLE on the next edge.

Test Plan:
- Reset then ADDU (op 0, func 100001), no waits:
  - IDLE 1 cycle → FETCH (ir_write=1) → EXEC (pc_write=1) → FETCH;
  - retired=1 after 4 edges.
- MULT with MUL_CYCLES=4:
  - muldiv_start high exactly 1 cycle in EXEC, then 4 MD_WAIT cycles with stall=1;
  - hilo_write=pc_write=1 only in the 4th; FETCH reached 5 cycles after entering EXEC.
- DIVU with DIV_CYCLES=32, reset_n pulsed low at the 10th MD_WAIT cycle:
  - immediate IDLE, hilo_write never asserted, retired=0.
- LW with mem_waitrequest high for 3 cycles from EXEC: EXEC → MEM_WAIT ×3 with stall=1 → pc_write on the 4th cycle.
- Instruction fetch with mem_waitrequest high 2 cycles: FETCH held 3 cycles, ir_write only in the 3rd.
- JR with halt_req=1 in EXEC:
  - pc_write=1, then HALT with active=0;
  - further instructions and halt_req toggles leave retired unchanged.
- RETIRE_W=4: 16 back-to-back ADDU retires → retired wraps 15→0.
